// File: rtl/fc_mac_arbiter_if.sv
// ---------------------------------------------------------------------------
// fc_mac_arbiter_if
// Request/grant bundle between the FC MAC requesters and fc_mac_arbiter.
//   req        requester -> arbiter   OUT_SZ  level request, bit i = requester i
//   done       requester -> arbiter   1       one-cycle release pulse from owner
//   grant      arbiter -> requester   OUT_SZ  registered one-hot grant
//   grant_idx  arbiter -> requester   SIZE    binary owner index (Decoder select)
//   grant_vld  arbiter -> requester   1       a grant is held (== |grant)
//   timeout    arbiter -> requester   1       one-cycle forced-release pulse
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface fc_mac_arbiter_if #(
   parameter int unsigned SIZE   = 2,
   parameter int unsigned OUT_SZ = 4
);
   logic [OUT_SZ-1:0] req;
   logic              done;
   logic [OUT_SZ-1:0] grant;
   logic [SIZE-1:0]   grant_idx;
   logic              grant_vld;
   logic              timeout;

   modport master (
      output req, done,
      input  grant, grant_idx, grant_vld, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_idx, grant_vld, timeout
   );
endinterface

// File: rtl/fc_mac_arbiter.sv
// ---------------------------------------------------------------------------
// fc_mac_arbiter
// Round-robin arbiter sharing the single fully-connected MAC datapath between
// OUT_SZ requesters. A requester raises req, waits for its one-hot grant, and
// owns the MAC until it pulses done. At least one idle cycle (grant = 0)
// separates two grants so the MAC datapath always gets a drain gap.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  fc_mac_arbiter_if.slave (req, done in; grant, grant_idx, grant_vld,
//        timeout out)
// Optional feature: define FC_ARB_TIMEOUT_EN to force a release after a grant
// has been held TIMEOUT cycles without done; otherwise timeout is tied to 0 and
// a grant is held until done.
// ---------------------------------------------------------------------------
module fc_mac_arbiter #(
   parameter int unsigned SIZE    = 2,
   parameter int unsigned OUT_SZ  = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   fc_mac_arbiter_if.slave  bus
);

   if (OUT_SZ != (1 << SIZE) || TIMEOUT < 1) begin : g_param_check
      $error("fc_mac_arbiter: OUT_SZ must equal 2**SIZE and TIMEOUT must be >= 1");
   end

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state_q, state_d;
   logic [OUT_SZ-1:0] grant_q, grant_d;
   logic [SIZE-1:0]   idx_q;
   logic [SIZE-1:0]   ptr_q;
   logic [SIZE-1:0]   winner, cand;
   logic              found;
   logic              release_c;
   logic              expire;

`ifdef FC_ARB_TIMEOUT_EN
   localparam int unsigned     CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);
   logic [CW-1:0] cnt_q;
   logic          timeout_q;

   // cnt_q counts completed OWN cycles; expiry fires on the edge that ends
   // the TIMEOUT-th cycle of ownership.
   always_comb expire = (state_q == OWN) && (cnt_q == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= release_c && expire && !bus.done;
         if (state_q == IDLE) cnt_q <= '0;
         else                 cnt_q <= cnt_q + CW'(1);
      end
   end
`else
   always_comb expire = 1'b0;
`endif

   // Round-robin scan ptr, ptr+1, ... ; the SIZE-bit sum wraps modulo OUT_SZ.
   always_comb begin
      found  = 1'b0;
      winner = ptr_q;
      cand   = ptr_q;
      for (int unsigned i = 0; i < OUT_SZ; i++) begin
         cand = ptr_q + SIZE'(i);
         if (!found && bus.req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      grant_d         = '0;
      grant_d[winner] = 1'b1;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; done in IDLE is deliberately ignored.
   always_comb begin
      state_d   = state_q;
      release_c = 1'b0;
      case (state_q)
         IDLE: if (found) state_d = OWN;
         OWN: begin
            if (bus.done || expire) begin
               state_d   = IDLE;
               release_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant/pointer registers. Release always passes through IDLE, so a new
   // winner is only picked one cycle after the previous grant drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else if (state_q == IDLE && found) begin
         grant_q <= grant_d;
         idx_q   <= winner;
      end else if (release_c) begin
         grant_q <= '0;
         ptr_q   <= idx_q + SIZE'(1);
      end
   end

   // Outputs
   always_comb begin
      bus.grant     = grant_q;
      bus.grant_idx = idx_q;
      bus.grant_vld = |grant_q;
`ifdef FC_ARB_TIMEOUT_EN
      bus.timeout   = timeout_q;
`else
      bus.timeout   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_fc_mac_arbiter.sv
module tb_fc_mac_arbiter;
   localparam int SIZE    = 2;
   localparam int OUT_SZ  = 4;
   localparam int TIMEOUT = 8;
`ifdef FC_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fc_mac_arbiter_if #(.SIZE(SIZE), .OUT_SZ(OUT_SZ)) bus ();

   fc_mac_arbiter #(.SIZE(SIZE), .OUT_SZ(OUT_SZ), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   // Reference model: who owns the MAC, where the scan starts, how long held.
   int owner = -1;
   int ptr   = 0;
   int held  = 0;
   bit exp_to = 1'b0;

   function automatic logic [3:0] exp_grant();
      return (owner < 0) ? 4'b0000 : 4'(1 << owner);
   endfunction

   task automatic model_reset();
      owner  = -1;
      ptr    = 0;
      held   = 0;
      exp_to = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic d);
      exp_to = 1'b0;
      if (owner < 0) begin
         for (int k = 0; k < OUT_SZ; k++) begin
            if (owner < 0 && r[(ptr + k) % OUT_SZ]) begin
               owner = (ptr + k) % OUT_SZ;
               held  = 1;
            end
         end
      end else if (d) begin
         ptr   = (owner + 1) % OUT_SZ;
         owner = -1;
      end else if (TO_EN && held == TIMEOUT) begin
         ptr    = (owner + 1) % OUT_SZ;
         owner  = -1;
         exp_to = 1'b1;
      end else begin
         held++;
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, settle 1 time unit.
   task automatic cyc(input logic [3:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      bus.req  = 4'b1111;
      bus.done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.grant, bus.grant_vld, bus.timeout} !== 6'b0)
         $display("FAIL reset_state: got grant=%b vld=%b to=%b required 0000/0/0",
                  bus.grant, bus.grant_vld, bus.timeout);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cyc(4'b1111, 1'b0);
      checks++;
      if (bus.grant !== 4'b0001 || bus.grant_idx !== 2'd0 || bus.grant_vld !== 1'b1)
         $display("FAIL reset_first_grant: got %b idx=%0d vld=%b required 0001 idx=0 vld=1",
                  bus.grant, bus.grant_idx, bus.grant_vld);
      else passed++;
      // Reset mid-ownership must clear the grant without a clock edge.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.grant !== 4'b0000 || bus.grant_vld !== 1'b0)
         $display("FAIL reset_async: got %b vld=%b required 0000 vld=0", bus.grant, bus.grant_vld);
      else passed++;
      @(negedge clk);
      rst     = 1'b0;
      bus.req = '0;
      model_reset();
   endtask

   task automatic test_single();
      do_reset();
      cyc(4'b0100, 1'b0);
      checks++;
      if (bus.grant !== 4'b0100 || bus.grant_idx !== 2'd2 || bus.grant_vld !== 1'b1)
         $display("FAIL single_grant: got %b idx=%0d required 0100 idx=2", bus.grant, bus.grant_idx);
      else passed++;
      cyc(4'b0100, 1'b1);
      checks++;
      if (bus.grant !== 4'b0000 || bus.grant_vld !== 1'b0)
         $display("FAIL single_release: got %b required 0000", bus.grant);
      else passed++;
   endtask

   task automatic test_rotation();
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(4'b1111, 1'b0);
         checks++;
         if (bus.grant !== seq[i])
            $display("FAIL rotation_grant%0d: got %b required %b", i, bus.grant, seq[i]);
         else passed++;
         cyc(4'b1111, 1'b1);
         checks++;
         if (bus.grant !== 4'b0000)
            $display("FAIL rotation_gap%0d: got %b required 0000", i, bus.grant);
         else passed++;
      end
   endtask

   task automatic test_ptr_skip();
      do_reset();
      cyc(4'b0010, 1'b0);
      cyc(4'b0010, 1'b1);
      cyc(4'b0011, 1'b0);
      checks++;
      if (bus.grant !== 4'b0001)
         $display("FAIL ptr_skip_first: got %b required 0001", bus.grant);
      else passed++;
      cyc(4'b0011, 1'b1);
      cyc(4'b0011, 1'b0);
      checks++;
      if (bus.grant !== 4'b0010)
         $display("FAIL ptr_skip_second: got %b required 0010", bus.grant);
      else passed++;
   endtask

   task automatic test_frozen();
      do_reset();
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      cyc(4'b0001, 1'b0);
      checks++;
      if (bus.grant !== 4'b1000 || bus.grant_idx !== 2'd3)
         $display("FAIL frozen_hold: got %b idx=%0d required 1000 idx=3", bus.grant, bus.grant_idx);
      else passed++;
      cyc(4'b0011, 1'b1);
      checks++;
      if (bus.grant !== 4'b0000)
         $display("FAIL frozen_gap: got %b required 0000", bus.grant);
      else passed++;
      cyc(4'b0011, 1'b0);
      checks++;
      if (bus.grant !== 4'b0001)
         $display("FAIL frozen_next: got %b required 0001", bus.grant);
      else passed++;
   endtask

   task automatic test_timeout();
      do_reset();
      cyc(4'b0010, 1'b0);
`ifdef FC_ARB_TIMEOUT_EN
      for (int i = 1; i < TIMEOUT; i++) begin
         cyc(4'b0000, 1'b0);
         checks++;
         if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0)
            $display("FAIL timeout_hold%0d: got %b to=%b required 0010 to=0", i, bus.grant, bus.timeout);
         else passed++;
      end
      cyc(4'b0000, 1'b0);
      checks++;
      if (bus.grant !== 4'b0000 || bus.timeout !== 1'b1)
         $display("FAIL timeout_fire: got %b to=%b required 0000 to=1", bus.grant, bus.timeout);
      else passed++;
      cyc(4'b0000, 1'b0);
      checks++;
      if (bus.timeout !== 1'b0)
         $display("FAIL timeout_pulse: got to=%b required 0", bus.timeout);
      else passed++;
      // done on the expiry edge is an ordinary release
      cyc(4'b0100, 1'b0);
      for (int i = 1; i < TIMEOUT; i++) cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b1);
      checks++;
      if (bus.grant !== 4'b0000 || bus.timeout !== 1'b0)
         $display("FAIL timeout_done_tie: got %b to=%b required 0000 to=0", bus.grant, bus.timeout);
      else passed++;
`else
      for (int i = 0; i < 110; i++) begin
         cyc(4'b0000, 1'b0);
         checks++;
         if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0)
            $display("FAIL hold_forever%0d: got %b to=%b required 0010 to=0", i, bus.grant, bus.timeout);
         else passed++;
      end
      cyc(4'b0000, 1'b1);
`endif
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       d;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r = 4'($urandom);
         d = ($urandom_range(0, 9) == 0);
         cyc(r, d);
         checks++;
         if ({bus.grant, bus.grant_vld, bus.timeout} !== {exp_grant(), owner >= 0, exp_to})
            $display("FAIL random%0d: got grant=%b vld=%b to=%b required %b/%b/%b", i,
                     bus.grant, bus.grant_vld, bus.timeout, exp_grant(), owner >= 0, exp_to);
         else passed++;
         if (owner >= 0) begin
            checks++;
            if (bus.grant_idx !== 2'(owner))
               $display("FAIL random_idx%0d: got %0d required %0d", i, bus.grant_idx, owner);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_ptr_skip();
      test_frozen();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
